// File: rtl/izh_spike_monitor.sv
// izh_spike_monitor: windowed spike-rate / inter-spike-interval monitor for
// an Izhikevich neuron core. Counts rising edges of spike_in per window.
// Tracks the latest inter-spike interval and flags windows that contain a
// short (bursting) interval. Completed windows are published as a record
// with a valid/ready handshake and a sticky overrun flag.
module izh_spike_monitor #(
    parameter int CNT_W     = 8,
    parameter int ISI_W     = 12,
    parameter int BURST_ISI = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [15:0]      win_len,
    input  logic             clear,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_out,
    output logic             burst_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ISI_W-1:0] ISI_MAX   = '1;
    localparam logic [ISI_W-1:0] ISI_ONE   = ISI_W'(1);
    localparam logic [ISI_W-1:0] BURST_LIM = ISI_W'(BURST_ISI);

    state_t           state_reg, state_next;
    logic             spike_prev_reg;
    logic [15:0]      len_reg, len_next;
    logic [15:0]      win_cnt_reg, win_cnt_next;
    logic [CNT_W-1:0] spike_cnt_reg, spike_cnt_next;
    logic [ISI_W-1:0] isi_cnt_reg, isi_cnt_next;
    logic             seen_reg, seen_next;
    logic             burst_win_reg, burst_win_next;
    logic [ISI_W-1:0] isi_reg, isi_next;
    logic [CNT_W-1:0] rate_reg, rate_next;
    logic             burst_reg, burst_next;
    logic             valid_reg, valid_next;
    logic             overrun_reg, overrun_next;

    logic             spike_event;
    logic             win_start;
    logic             terminal;
    logic             measure;
    logic             burst_hit;
    logic             burst_acc;
    logic [15:0]      cur_len;
    logic [15:0]      cur_cnt;
    logic [ISI_W-1:0] isi_meas;
    logic [CNT_W-1:0] cnt_inc;

    // Window position, ISI measurement and saturating count for this cycle.
    // In IDLE the current cycle is treated as cycle 0 of a fresh window, so
    // the very first enabled cycle already belongs to the first window.
    always_comb begin
        spike_event = spike_in & ~spike_prev_reg;
        win_start   = (state_reg == IDLE) || (win_cnt_reg == 16'd0);
        cur_cnt     = (state_reg == IDLE) ? 16'd0 : win_cnt_reg;
        if (win_start) begin
            cur_len = (win_len == 16'd0) ? 16'd1 : win_len;
        end else begin
            cur_len = len_reg;
        end
        terminal  = ena && (cur_cnt == (cur_len - 16'd1));
        measure   = ena && spike_event && seen_reg;
        isi_meas  = (isi_cnt_reg == ISI_MAX) ? ISI_MAX : (isi_cnt_reg + ISI_ONE);
        burst_hit = measure && (isi_meas <= BURST_LIM);
        burst_acc = burst_win_reg | burst_hit;
        if (ena && spike_event && (spike_cnt_reg != CNT_MAX)) begin
            cnt_inc = spike_cnt_reg + CNT_ONE;
        end else begin
            cnt_inc = spike_cnt_reg;
        end
    end

    // Next-state logic for the FSM, window counters and the output record.
    // clear overrides everything; the handshake runs even while ena is low.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        win_cnt_next   = win_cnt_reg;
        spike_cnt_next = spike_cnt_reg;
        isi_cnt_next   = isi_cnt_reg;
        seen_next      = seen_reg;
        burst_win_next = burst_win_reg;
        isi_next       = isi_reg;
        rate_next      = rate_reg;
        burst_next     = burst_reg;
        valid_next     = valid_reg;
        overrun_next   = overrun_reg;

        if (clear) begin
            state_next     = IDLE;
            len_next       = 16'd0;
            win_cnt_next   = 16'd0;
            spike_cnt_next = '0;
            isi_cnt_next   = '0;
            seen_next      = 1'b0;
            burst_win_next = 1'b0;
            isi_next       = '0;
            rate_next      = '0;
            burst_next     = 1'b0;
            valid_next     = 1'b0;
            overrun_next   = 1'b0;
        end else begin
            if (ena) begin
                state_next = RUN;
                if (win_start) begin
                    len_next = cur_len;
                end
                isi_cnt_next = (isi_cnt_reg == ISI_MAX) ? ISI_MAX : (isi_cnt_reg + ISI_ONE);
                if (spike_event) begin
                    isi_cnt_next = '0;
                    seen_next    = 1'b1;
                end
                if (measure) begin
                    isi_next = isi_meas;
                end
                if (terminal) begin
                    win_cnt_next   = 16'd0;
                    spike_cnt_next = '0;
                    burst_win_next = 1'b0;
                    rate_next      = cnt_inc;
                    burst_next     = burst_acc;
                end else begin
                    win_cnt_next   = cur_cnt + 16'd1;
                    spike_cnt_next = cnt_inc;
                    burst_win_next = burst_acc;
                end
            end
            if (terminal) begin
                valid_next = 1'b1;
                if (valid_reg && !out_ready) begin
                    overrun_next = 1'b1;
                end
            end else if (valid_reg && out_ready) begin
                valid_next = 1'b0;
            end
        end
    end

    // State registers; the previous-spike sample tracks spike_in every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            spike_prev_reg <= 1'b0;
            len_reg        <= 16'd0;
            win_cnt_reg    <= 16'd0;
            spike_cnt_reg  <= '0;
            isi_cnt_reg    <= '0;
            seen_reg       <= 1'b0;
            burst_win_reg  <= 1'b0;
            isi_reg        <= '0;
            rate_reg       <= '0;
            burst_reg      <= 1'b0;
            valid_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            spike_prev_reg <= spike_in;
            len_reg        <= len_next;
            win_cnt_reg    <= win_cnt_next;
            spike_cnt_reg  <= spike_cnt_next;
            isi_cnt_reg    <= isi_cnt_next;
            seen_reg       <= seen_next;
            burst_win_reg  <= burst_win_next;
            isi_reg        <= isi_next;
            rate_reg       <= rate_next;
            burst_reg      <= burst_next;
            valid_reg      <= valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign rate_out  = rate_reg;
    assign isi_out   = isi_reg;
    assign burst_out = burst_reg;
    assign out_valid = valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Self-checking bench for izh_spike_monitor: a timestamp-based model of the
// monitor is compared with the DUT every cycle, and directed scenarios pin
// hand-computed record values.
module tb_izh_spike_monitor;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        ena       = 1'b0;
    logic        spike_in  = 1'b0;
    logic [15:0] win_len   = 16'd10;
    logic        clear     = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  rate_out;
    logic [11:0] isi_out;
    logic        burst_out;
    logic        out_valid;
    logic        overrun;

    int vectors    = 0;
    int miscompares = 0;
    int valid_seen = 0;

    typedef struct {
        int    sel;
        int    val;
        string tag;
    } lit_t;
    lit_t lq[$];

    izh_spike_monitor #(.CNT_W(8), .ISI_W(12), .BURST_ISI(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spike_in (spike_in),
        .win_len  (win_len),
        .clear    (clear),
        .rate_out (rate_out),
        .isi_out  (isi_out),
        .burst_out(burst_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (enabled-cycle timestamps) --------
    int t_en, win_start_t, win_end_t, last_t, m_cnt;
    bit m_run, m_seen, m_prev, m_burst_w;
    int exp_rate, exp_isi;
    bit exp_burst, exp_valid, exp_ovr;

    always @(posedge clk or negedge rst_n) begin
        bit ev;
        bit load;
        int len;
        int d;
        if (!rst_n) begin
            t_en = 0; win_start_t = 0; win_end_t = 0; last_t = 0; m_cnt = 0;
            m_run = 0; m_seen = 0; m_prev = 0; m_burst_w = 0;
            exp_rate = 0; exp_isi = 0; exp_burst = 0; exp_valid = 0; exp_ovr = 0;
        end else begin
            ev     = spike_in && !m_prev;
            m_prev = spike_in;
            load   = 0;
            if (clear) begin
                m_run = 0; t_en = 0; m_cnt = 0; m_seen = 0; m_burst_w = 0;
                exp_rate = 0; exp_isi = 0; exp_burst = 0; exp_valid = 0; exp_ovr = 0;
            end else begin
                if (ena) begin
                    if (!m_run) begin
                        m_run = 1;
                        win_start_t = t_en;
                    end
                    if (t_en == win_start_t) begin
                        len = (win_len == 16'd0) ? 1 : int'(win_len);
                        win_end_t = t_en + len - 1;
                    end
                    if (ev) begin
                        if (m_seen) begin
                            d = t_en - last_t;
                            exp_isi = (d > 4095) ? 4095 : d;
                            if (d <= 8) m_burst_w = 1;
                        end
                        m_seen = 1;
                        last_t = t_en;
                        m_cnt++;
                    end
                    if (t_en == win_end_t) begin
                        load = 1;
                        exp_rate  = (m_cnt > 255) ? 255 : m_cnt;
                        exp_burst = m_burst_w;
                        m_cnt = 0;
                        m_burst_w = 0;
                        win_start_t = t_en + 1;
                    end
                    t_en++;
                end
                if (load) begin
                    if (exp_valid && !out_ready) exp_ovr = 1;
                    exp_valid = 1;
                end else if (exp_valid && out_ready) begin
                    exp_valid = 0;
                end
            end
        end
    end

    // ---------------- single compare process -------------------------------
    always @(negedge clk) begin
        lit_t l;
        int   act;
        vectors++;
        if (int'(rate_out) != exp_rate || int'(isi_out) != exp_isi ||
            burst_out !== exp_burst || out_valid !== exp_valid || overrun !== exp_ovr) begin
            miscompares++;
            $display("FAIL model t=%0t: rate %0d/%0d isi %0d/%0d burst %0b/%0b valid %0b/%0b overrun %0b/%0b (got/expected)",
                     $time, rate_out, exp_rate, isi_out, exp_isi, burst_out, exp_burst,
                     out_valid, exp_valid, overrun, exp_ovr);
        end
        if (out_valid) valid_seen++;
        while (lq.size() > 0) begin
            l = lq.pop_front();
            case (l.sel)
                1:       act = int'(rate_out);
                2:       act = int'(isi_out);
                3:       act = int'(burst_out);
                4:       act = int'(overrun);
                5:       act = int'(out_valid);
                default: act = valid_seen;
            endcase
            vectors++;
            if (act != l.val) begin
                miscompares++;
                $display("FAIL %s t=%0t: got %0d expected %0d", l.tag, $time, act, l.val);
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic lit(input int sel, input int val, input string tag);
        lit_t l;
        l.sel = sel; l.val = val; l.tag = tag;
        lq.push_back(l);
    endtask

    task automatic step(input logic e, input logic s, input logic c);
        @(posedge clk);
        #2;
        ena = e; spike_in = s; clear = c;
    endtask

    task automatic run(input int n, input int per, input logic e);
        for (int i = 0; i < n; i++) step(e, (per > 0) && ((i % per) == 0), 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        // reset state
        lit(1, 0, "reset_rate"); lit(5, 0, "reset_valid"); lit(4, 0, "reset_overrun");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 100-cycle windows, spike every 10 cycles
        win_len = 16'd100; out_ready = 1'b1;
        do_clear();
        base = valid_seen;
        run(250, 10, 1'b1);
        lit(6, base + 2, "win100_pulses");
        lit(1, 10, "win100_rate"); lit(2, 10, "win100_isi"); lit(3, 0, "win100_burst");

        // 20-cycle windows, spikes 4 apart -> bursting
        win_len = 16'd20;
        do_clear();
        run(45, 4, 1'b1);
        lit(1, 5, "win20_rate"); lit(2, 4, "win20_isi"); lit(3, 1, "win20_burst");

        // consumer stalled -> overrun, newest record kept
        win_len = 16'd10; out_ready = 1'b0;
        do_clear();
        run(25, 3, 1'b1);
        lit(4, 1, "stall_overrun"); lit(1, 3, "stall_rate"); lit(5, 1, "stall_valid");
        out_ready = 1'b1;
        run(5, 0, 1'b1);
        lit(4, 1, "overrun_sticky");
        do_clear();
        step(1'b0, 1'b0, 1'b0);
        lit(4, 0, "clear_overrun"); lit(1, 0, "clear_rate"); lit(5, 0, "clear_valid");

        // spike on the terminal cycle belongs to the closing window
        win_len = 16'd10;
        do_clear();
        for (int i = 0; i < 15; i++) step(1'b1, i == 9, 1'b0);
        lit(1, 1, "terminal_spike_rate");
        for (int i = 15; i < 25; i++) step(1'b1, 1'b0, 1'b0);
        lit(1, 0, "next_window_rate");

        // held-high input is one event; disabled toggling is ignored
        win_len = 16'd60;
        do_clear();
        for (int i = 0; i < 70; i++) step(1'b1, i < 50, 1'b0);
        lit(1, 1, "held_high_rate");
        for (int i = 0; i < 20; i++) step(1'b0, i[0], 1'b0);
        lit(1, 1, "ena_low_rate");

        // count saturation
        win_len = 16'd700;
        do_clear();
        run(705, 2, 1'b1);
        lit(1, 255, "sat_rate"); lit(2, 2, "sat_isi"); lit(3, 1, "sat_burst");

        // zero length behaves as one-cycle windows
        win_len = 16'd0;
        do_clear();
        run(4, 0, 1'b1);
        lit(5, 1, "len0_valid");

        // asynchronous reset mid-window
        win_len = 16'd50;
        do_clear();
        run(20, 3, 1'b1);
        lit(2, 3, "pre_reset_isi");
        @(posedge clk);
        #2;
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; clear = 1'b0;
        lit(2, 0, "in_reset_isi"); lit(1, 0, "in_reset_rate");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        lit(2, 0, "first_spike_isi");
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        lit(2, 8, "second_spike_isi");
        run(45, 0, 1'b1);
        lit(1, 2, "post_reset_rate");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
